// File: rtl/pio_stepper_driver.sv
// pio_stepper_driver: turns the 6-bit PIO control word into 4-phase unipolar
// stepper coil drive, with a step-rate prescaler, a 3-bit sequence position
// and a free-running step counter.
// Optional build macro STEPPER_DIR_DWELL_EN: a direction change while running
// restarts the prescaler and stretches the next step to two periods, so the
// rotor settles before it reverses.
module pio_stepper_driver #(
    parameter int DIV_BASE = 50000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       ctrl_in,
    output logic [3:0]       phases,
    output logic             step_pulse,
    output logic [CNT_W-1:0] step_count,
    output logic             busy
);

    // Wide enough for a doubled period; the prescaler never exceeds the
    // largest limit because it clears as soon as it reaches the limit.
    localparam int CW = $clog2(2 * DIV_BASE) + 1;

    localparam logic [1:0] MODE_WAVE = 2'b00;
    localparam logic [1:0] MODE_FULL = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    logic [5:0]    ctrl_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] period;
    logic [CW-1:0] limit;
    logic [2:0]    pos;
    logic [2:0]    pos_nxt;
    logic [1:0]    pair_nxt;
    logic          step;
    logic          en;
    logic          dir;
    logic [1:0]    speed;
    logic [1:0]    mode;

    assign en    = ctrl_q[0];
    assign dir   = ctrl_q[1];
    assign speed = ctrl_q[3:2];
    assign mode  = ctrl_q[5:4];
    assign busy  = ctrl_q[0];

    assign period = CW'(DIV_BASE) >> speed;

    // Wave and full drive move by whole coil pairs; the low bit selects the
    // single-coil (0) or two-coil (1) pattern inside the pair.
    assign pair_nxt = dir ? (pos[2:1] + 2'd1) : (pos[2:1] - 2'd1);

`ifdef STEPPER_DIR_DWELL_EN
    logic dwell;
    logic dwell_nxt;
    logic dir_chg;

    // Detected on the edge that registers the new direction.
    assign dir_chg = en && (mode != MODE_HOLD) && (ctrl_in[1] != ctrl_q[1]);
    assign limit   = dwell ? ((period << 1) - CW'(1)) : (period - CW'(1));
`else
    assign limit   = period - CW'(1);
`endif

    // Prescaler, step decision and next sequence position.
    always_comb begin
        cnt_nxt = cnt;
        pos_nxt = pos;
        step    = 1'b0;
`ifdef STEPPER_DIR_DWELL_EN
        dwell_nxt = dwell;
`endif
        if (!en) begin
            cnt_nxt = '0;
`ifdef STEPPER_DIR_DWELL_EN
            dwell_nxt = 1'b0;
        end else if (dir_chg) begin
            cnt_nxt   = '0;
            dwell_nxt = 1'b1;
`endif
        end else if (cnt >= limit) begin
            // >= so a speed increase past the new limit steps immediately.
            cnt_nxt = '0;
            if (mode != MODE_HOLD) begin
                step = 1'b1;
`ifdef STEPPER_DIR_DWELL_EN
                dwell_nxt = 1'b0;
`endif
                case (mode)
                    MODE_WAVE: pos_nxt = {pair_nxt, 1'b0};
                    MODE_FULL: pos_nxt = {pair_nxt, 1'b1};
                    MODE_HALF: pos_nxt = dir ? (pos + 3'd1) : (pos - 3'd1);
                    default:   pos_nxt = pos;
                endcase
            end
        end else begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    // Control capture, prescaler, position and step bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            cnt        <= '0;
            pos        <= '0;
            step_pulse <= 1'b0;
            step_count <= '0;
        end else begin
            ctrl_q     <= ctrl_in;
            cnt        <= cnt_nxt;
            pos        <= pos_nxt;
            step_pulse <= step;
            if (step) begin
                step_count <= step_count + CNT_W'(1);
            end
        end
    end

`ifdef STEPPER_DIR_DWELL_EN
    // Dwell flag: armed by a direction change, cleared by the stretched step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell <= 1'b0;
        end else begin
            dwell <= dwell_nxt;
        end
    end
`endif

    // Coil pattern lookup; all coils off while disabled.
    always_comb begin
        phases = 4'b0000;
        if (en) begin
            case (pos)
                3'd0: phases = 4'b0001;
                3'd1: phases = 4'b0011;
                3'd2: phases = 4'b0010;
                3'd3: phases = 4'b0110;
                3'd4: phases = 4'b0100;
                3'd5: phases = 4'b1100;
                3'd6: phases = 4'b1000;
                3'd7: phases = 4'b1001;
                default: phases = 4'b0000;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_stepper_driver.sv
// tb_pio_stepper_driver: directed scenarios followed by randomized control
// words, every cycle compared against an arithmetic reference model.
// Honours STEPPER_DIR_DWELL_EN the same way the design does.
module tb_pio_stepper_driver;

    localparam int DIV_BASE = 16;
    localparam int CNT_W    = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [5:0]       ctrl_in = 6'h00;
    logic [3:0]       phases;
    logic             step_pulse;
    logic [CNT_W-1:0] step_count;
    logic             busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: registered control word, cycles into the
    // current period, sequence index 0..7, steps taken, dwell pending.
    logic [5:0] m_ctrl = 6'h00;
    int         m_cnt = 0;
    int         m_pos = 0;
    int         m_steps = 0;
    bit         m_pulse = 1'b0;
    bit         m_dwell = 1'b0;
    int         tbl [8] = '{1, 3, 2, 6, 4, 12, 8, 9};

    pio_stepper_driver #(.DIV_BASE(DIV_BASE), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ctrl_in    (ctrl_in),
        .phases     (phases),
        .step_pulse (step_pulse),
        .step_count (step_count),
        .busy       (busy)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_ctrl  = 6'h00;
        m_cnt   = 0;
        m_pos   = 0;
        m_steps = 0;
        m_pulse = 1'b0;
        m_dwell = 1'b0;
    endfunction

    // One clock edge of the reference: nxt is the word being registered.
    function automatic void model_edge(input logic [5:0] nxt);
        int period;
        int span;
        int d;
        int mode;
        period  = DIV_BASE >> m_ctrl[3:2];
        d       = m_ctrl[1] ? 1 : -1;
        mode    = int'(m_ctrl[5:4]);
        m_pulse = 1'b0;
        if (!m_ctrl[0]) begin
            m_cnt   = 0;
            m_dwell = 1'b0;
        end
`ifdef STEPPER_DIR_DWELL_EN
        else if (mode != 3 && nxt[1] != m_ctrl[1]) begin
            m_cnt   = 0;
            m_dwell = 1'b1;
        end
`endif
        else begin
            span = m_dwell ? 2 * period : period;
            if (m_cnt + 1 < span) begin
                m_cnt++;
            end else begin
                m_cnt = 0;
                if (mode != 3) begin
                    m_pulse = 1'b1;
                    m_dwell = 1'b0;
                    m_steps++;
                    if (mode == 0)      m_pos = (((m_pos / 2) + d + 4) % 4) * 2;
                    else if (mode == 1) m_pos = (((m_pos / 2) + d + 4) % 4) * 2 + 1;
                    else                m_pos = (m_pos + d + 8) % 8;
                end
            end
        end
        m_ctrl = nxt;
    endfunction

    task automatic check_all();
        chk("phases", 32'(phases), m_ctrl[0] ? tbl[m_pos] : 0);
        chk("step_pulse", 32'(step_pulse), 32'(m_pulse));
        chk("step_count", 32'(step_count), m_steps & 32'hFFFF);
        chk("busy", 32'(busy), 32'(m_ctrl[0]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge(ctrl_in);
        #1;
        check_all();
    endtask

    task automatic wait_step(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (step_pulse !== 1'b1 && n < budget);
    endtask

    logic [3:0] exp_half [8] = '{4'b0011, 4'b0010, 4'b0110, 4'b0100,
                                 4'b1100, 4'b1000, 4'b1001, 4'b0001};
    logic [3:0] exp_full [5] = '{4'b1001, 4'b1100, 4'b0110, 4'b0011, 4'b1001};

    initial begin
        int n;
        int hold;
        model_reset();

        // Reset state with every control bit set.
        reset_n = 1'b0;
        ctrl_in = 6'h3F;
        #12;
        chk("t1_phases", 32'(phases), 0);
        chk("t1_pulse", 32'(step_pulse), 0);
        chk("t1_count", 32'(step_count), 0);
        chk("t1_busy_rst", 32'(busy), 0);
        reset_n = 1'b1;
        tick();
        chk("t1_busy", 32'(busy), 1);

        // Half step forward, speed 0: full 8-step cycle with wrap.
        ctrl_in = 6'b00_00_00;
        tick();
        tick();
        ctrl_in = 6'b10_00_11;
        for (int i = 0; i < 8; i++) begin
            wait_step(40, n);
            chk("t2_gap", n, (i == 0) ? 17 : 16);
            chk("t2_phase", 32'(phases), 32'(exp_half[i]));
        end
        chk("t2_count", 32'(step_count), 8);

        // Full step reverse at speed 3 from position 0.
        ctrl_in = 6'b01_11_00;
        tick();
        ctrl_in = 6'b01_11_01;
        for (int i = 0; i < 5; i++) begin
            wait_step(10, n);
            chk("t3_gap", n, (i == 0) ? 3 : 2);
            chk("t3_phase", 32'(phases), 32'(exp_full[i]));
        end
        chk("t3_count", 32'(step_count), 13);

        // Hold freezes everything; disable blanks coils; re-enable resumes.
        ctrl_in = 6'b11_11_01;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t4_hold_pulse", 32'(step_pulse), 0);
            chk("t4_hold_phase", 32'(phases), 32'(4'b1001));
            chk("t4_hold_count", 32'(step_count), 13);
        end
        ctrl_in = 6'b11_11_00;
        tick();
        chk("t4_off_phase", 32'(phases), 0);
        tick();
        tick();
        ctrl_in = 6'b01_00_01;
        wait_step(40, n);
        chk("t4_resume_gap", n, 17);
        chk("t4_resume_phase", 32'(phases), 32'(4'b1100));

        // Speed jump from cnt=10 at speed 0 to speed 2.
        for (int i = 0; i < 10; i++) tick();
        ctrl_in = 6'b01_10_01;
        wait_step(20, n);
        chk("t5_jump_gap", n, 2);
        chk("t5_jump_phase", 32'(phases), 32'(4'b0110));
        wait_step(20, n);
        chk("t5_gap", n, 4);
        chk("t5_phase", 32'(phases), 32'(4'b0011));

        // Direction toggle mid-period.
        ctrl_in = 6'b01_00_01;
        wait_step(40, n);
        chk("t6_pre_gap", n, 16);
        chk("t6_pre_phase", 32'(phases), 32'(4'b1001));
        for (int i = 0; i < 5; i++) tick();
        ctrl_in = 6'b01_00_11;
        wait_step(60, n);
`ifdef STEPPER_DIR_DWELL_EN
        chk("t6_dwell_gap", n, 33);
`else
        chk("t6_dir_gap", n, 11);
`endif
        chk("t6_phase", 32'(phases), 32'(4'b0011));

        // Randomized control words with occasional asynchronous reset.
        for (int seg = 0; seg < 40; seg++) begin
            ctrl_in    = 6'($urandom_range(0, 63));
            ctrl_in[0] = ($urandom_range(0, 3) != 0);
            hold = $urandom_range(1, 30);
            for (int i = 0; i < hold; i++) tick();
            if ($urandom_range(0, 9) == 0) begin
                reset_n = 1'b0;
                #2;
                model_reset();
                check_all();
                #3;
                reset_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pio_stepper_driver.md
Name: pio_stepper_driver

Overview:
- Downstream consumer of the 6-bit Avalon PIO output port; turns the CPU-written control word into 4-phase unipolar stepper coil drive.
- Contains a step-rate prescaler, a 3-bit sequence position counter and a step counter.
- Sits between the PIO `out_port` and the board-level coil driver pins, in the same clock domain as the PIO.

Parameters:
- DIV_BASE, 50000, clock cycles per step at speed 0; must be ≥16 and a multiple of 8.
- CNT_W, 16, width of step_count.

Ports:
- clk  input  1  system clock, same clock as the PIO
- reset_n  input  1  asynchronous active-low reset
- ctrl_in  input  6  PIO control word: [0] enable, [1] direction (1=forward), [3:2] speed, [5:4] mode
- phases  output  4  coil drive A,B,C,D (bit0=A)
- step_pulse  output  1  one-cycle strobe per executed step
- step_count  output  CNT_W  steps executed since reset; wraps modulo 2^CNT_W
- busy  output  1  registered enable bit (ctrl_q[0])

Behaviour:
Reset and input capture
- reset_n=0 clears ctrl_q, prescaler cnt, pos, step_pulse and step_count to 0.
- During reset: phases=0000, busy=0.
- ctrl_in is registered into ctrl_q every clk. All decisions use ctrl_q, which adds 1 cycle of latency.

Step period
- period = DIV_BASE >> speed, i.e. DIV_BASE, /2, /4, /8 for speed 0..3.

Prescaler
- While en=0: cnt held at 0; no steps; pos retained.
- While en=1: cnt increments each cycle.
- When cnt ≥ period-1, a step occurs: cnt←0 and step_pulse=1 for that cycle.
- Using ≥ means a speed increase that leaves cnt beyond the new period steps on the next cycle.
- The first step after the enable rising edge of ctrl_q occurs `period` cycles later.

Mode 00 and 11 (wave drive and hold)
- mode 11 (hold): cnt still counts, but no step, no step_pulse, and pos frozen. Coils keep the current pattern.
- mode 00 (wave): forward sets pos←{pos[2:1]+1,0}; reverse sets pos←{pos[2:1]-1,0}.

Mode 01 and 10 (full step and half step)
- mode 01 (full): forward sets pos←{pos[2:1]+1,1}; reverse sets pos←{pos[2:1]-1,1}.
- mode 10 (half): pos←pos±1.
- pos arithmetic wraps modulo 8 (7→0 and 0→7).
- A mode change with no step leaves pos unchanged. The next step realigns parity.

Phase table
- phases = en ? TABLE[pos] : 0000. This is combinational from registers, so it changes the cycle after the pos update edge.
- TABLE[0..7] = 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.

Step counter
- step_count increments by 1 on every step, regardless of direction.

Mid-operation events
- Direction change: takes effect at the next step; cnt is not disturbed (unless the optional feature is enabled).
- Disable mid-period: cnt→0 on the next edge and phases→0000. Re-enable starts a full period.
- reset_n asserted mid-step: all state clears immediately (asynchronous), including a pending step_pulse.

Optional Feature:
- Macro: STEPPER_DIR_DWELL_EN.
- Defined:
  - A change of ctrl_q[1] while en=1 and mode≠11 forces cnt←0 and arms a dwell flag.
  - The next step then requires 2×period cycles, with coils held on the current pattern.
  - The flag clears on that step, on disable or on reset.
  - A second direction change during the dwell restarts the dwell.
- Undefined: direction changes behave as in Behaviour, with no cnt disturbance and no dwell logic.

Test Plan (DIV_BASE=16, so periods are 16, 8, 4, 2):
1. Reset check: assert reset_n with ctrl_in=6'h3F. → phases=0000, step_pulse=0, step_count=0, busy=0. After release, busy=1 one cycle after the first clk edge.
2. Half step forward: ctrl_in=6'b10_00_11 (half, speed0, fwd, en). → step_pulse every 16 cycles. phases sequence 0001→0011→0010→0110→…→1001→0001 (wrap). step_count=8 after 8 steps.
3. Full step reverse at speed 3: from pos=0, ctrl_in=6'b01_11_01. → step every 2 cycles. phases 1001→1100→0110→0011→1001.
4. Hold then disable: switch mode to 11 mid-run. → no step_pulse, phases frozen, step_count constant. Then clear enable. → phases=0000 next cycle. Re-enable. → first step exactly 16 cycles later and pattern resumes from the retained pos.
5. Speed jump: at cnt=10, speed 0 changes to speed 2 (period 4). → step on the cycle after ctrl_q updates, then every 4 cycles.
6. Dwell (macro on): toggle direction mid-period. → next step_pulse arrives 32 cycles after the toggle is registered, with phases unchanged until then. With the macro off, the step arrives at the original period boundary.
